pow_rad_unit: RTL and testbench

//  Multi-cycle execution unit for the ALU_POW and ALU_RAD opcodes: unsigned power (A^B) and integer square root (floor(sqrt(A))).

---
 rtl/pow_rad_pkg.sv | 13 +
 rtl/pow_rad_unit_mul_trunc.sv | 17 +
 rtl/pow_rad_unit.sv | 156 +++++++++++++++
 tb/tb_pow_rad_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_rad_pkg.sv
// Shared opsel encodings for the ALU and the multi-cycle pow/rad unit.
package pow_rad_pkg;

    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_POW = 5'd20;
    localparam logic [4:0] ALU_RAD = 5'd21;

    function automatic logic is_multi(input logic [4:0] op);
        return (op == ALU_POW) || (op == ALU_RAD);
    endfunction

endpackage

// File: rtl/pow_rad_unit_mul_trunc.sv
// Combinational WIDTHxWIDTH multiply keeping the low WIDTH bits.
module pow_rad_unit_mul_trunc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);

    logic [2*WIDTH-1:0] prod;

    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign lo   = prod[WIDTH-1:0];
    assign ovf  = |prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/pow_rad_unit.sv
// Multi-cycle power / integer square root unit; ready doubles as loadPC.
module pow_rad_unit
    import pow_rad_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opsel,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic             is_pow;
    logic             ovf;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] root;

    logic             start;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] mp;
    logic             sq_ovf;
    logic             mp_ovf;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] root_nxt;
    logic             ovf_nxt;
    logic [WIDTH-1:0] res_nxt;

    assign start = is_multi(opsel);

    pow_rad_unit_mul_trunc #(.WIDTH(WIDTH)) u_sq (
        .a   (acc),
        .b   (acc),
        .lo  (sq),
        .ovf (sq_ovf)
    );

    pow_rad_unit_mul_trunc #(.WIDTH(WIDTH)) u_mp (
        .a   (sq),
        .b   (a_q),
        .lo  (mp),
        .ovf (mp_ovf)
    );

    // sh holds the exponent (POW) or radicand (RAD), consumed MSB first
    assign rem_sh = {rem[WIDTH-3:0], sh[WIDTH-1:WIDTH-2]};
    assign trial  = {root[WIDTH-3:0], 2'b01};

    always_comb begin
        acc_nxt  = sq;
        ovf_nxt  = ovf | sq_ovf;
        rem_nxt  = rem_sh;
        root_nxt = {root[WIDTH-2:0], 1'b0};
        if (sh[WIDTH-1]) begin
            acc_nxt = mp;
            ovf_nxt = ovf | sq_ovf | mp_ovf;
        end
        if (rem_sh >= trial) begin
            rem_nxt  = rem_sh - trial;
            root_nxt = {root[WIDTH-2:0], 1'b1};
        end
        res_nxt = is_pow ? acc_nxt : root_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            is_pow <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
            a_q    <= '0;
            sh     <= '0;
            acc    <= '0;
            rem    <= '0;
            root   <= '0;
            flags  <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_pow <= (opsel == ALU_POW);
                        a_q    <= srcA;
                        sh     <= (opsel == ALU_POW) ? srcB : srcA;
                        acc    <= WIDTH'(1);
                        rem    <= '0;
                        root   <= '0;
                        ovf    <= 1'b0;
                        cnt    <= (opsel == ALU_POW) ? CW'(WIDTH)
                                                     : CW'(WIDTH / 2);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt - CW'(1);
                    if (is_pow) begin
                        sh  <= sh << 1;
                        acc <= acc_nxt;
                        ovf <= ovf_nxt;
                    end else begin
                        sh   <= sh << 2;
                        rem  <= rem_nxt;
                        root <= root_nxt;
                    end
                    // flags become visible together with the DONE result
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        flags <= {res_nxt == '0, res_nxt[WIDTH-1],
                                  is_pow & ovf_nxt, is_pow & ovf_nxt};
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ready  = 1'b1;
        busy   = 1'b0;
        result = srcA;
        case (state)
            IDLE: begin
                ready = ~start;
                busy  = start;
            end
            CALC: begin
                ready  = 1'b0;
                busy   = 1'b1;
                result = a_q;
            end
            DONE:    result = is_pow ? acc : root;
            default: result = srcA;
        endcase
    end

endmodule

// File: tb/tb_pow_rad_unit.sv
// Randomized self-checking bench for pow_rad_unit against arithmetic models.
module tb_pow_rad_unit;
    import pow_rad_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  opsel;
    logic [15:0] srcA;
    logic [15:0] srcB;
    logic        ready;
    logic        busy;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks;
    int failures;
    logic [3:0] exp_flags;

    pow_rad_unit #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .opsel  (opsel),
        .srcA   (srcA),
        .srcB   (srcB),
        .ready  (ready),
        .busy   (busy),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pow_ref(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r, output logic o);
        longint p;
        p = 1;
        o = 1'b0;
        for (int i = 0; i < int'(b); i++) begin
            p = p * longint'(a);
            if (p > 65535) begin
                o = 1'b1;
                p = p & 65535;
            end
        end
        r = p[15:0];
    endtask

    function automatic logic [15:0] isqrt_ref(input logic [15:0] a);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        return r[15:0];
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [15:0] a,
                          input logic [15:0] b, input string name);
        logic [15:0] exp_r;
        logic        o;
        int          exp_n;
        int          n;
        logic        bad;
        if (op == ALU_POW) begin
            pow_ref(a, b, exp_r, o);
            exp_n = 17;
        end else begin
            exp_r = isqrt_ref(a);
            o     = 1'b0;
            exp_n = 9;
        end
        exp_flags = {exp_r == 16'h0, exp_r[15], o, o};
        @(negedge clk);
        opsel = op;
        srcA  = a;
        srcB  = b;
        #1;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1 || result !== a) begin
            failures++;
            $display("FAIL %s accept: ready=%b busy=%b result=%h want 0 1 %h",
                     name, ready, busy, result, a);
        end
        n   = 1;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            opsel = 5'($urandom);
            srcA  = 16'($urandom);
            srcB  = 16'($urandom);
            #1;
            if (ready === 1'b1) break;
            n++;
            if (result !== a || busy !== 1'b1) bad = 1'b1;
        end
        opsel = ALU_ADD;
        checks++;
        if (n != exp_n || ready !== 1'b1) begin
            failures++;
            $display("FAIL %s stall: cycles=%0d ready=%b want %0d 1",
                     name, n, ready, exp_n);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s stall_result: result/busy wrong while stalled, want %h",
                     name, a);
        end
        checks++;
        if (result !== exp_r || flags !== exp_flags) begin
            failures++;
            $display("FAIL %s done: result=%h flags=%b want %h %b",
                     name, result, flags, exp_r, exp_flags);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        opsel = ALU_ADD;
        srcA  = 16'h0;
        srcB  = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        srcA = 16'hBEEF;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || flags !== 4'b0
            || result !== 16'hBEEF) begin
            failures++;
            $display("FAIL reset: ready=%b busy=%b flags=%b result=%h",
                     ready, busy, flags, result);
        end
        exp_flags = 4'b0;
    endtask

    task automatic test_passthrough();
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opsel = (i == 0) ? ALU_ADD : ALU_SUB;
            srcA  = (i == 0) ? 16'h1234 : 16'($urandom);
            srcB  = 16'($urandom);
            #1;
            if (ready !== 1'b1 || busy !== 1'b0 || result !== srcA
                || flags !== exp_flags) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL passthrough: ready=%b result=%h flags=%b want 1 %h %b",
                     ready, result, flags, srcA, exp_flags);
        end
    endtask

    task automatic test_pow_edges();
        run_op(ALU_POW, 16'd3, 16'd4, "pow_3_4");
        run_op(ALU_POW, 16'd2, 16'd16, "pow_2_16");
        run_op(ALU_POW, 16'h00FF, 16'd2, "pow_ff_2");
        run_op(ALU_POW, 16'd7, 16'd0, "pow_7_0");
        run_op(ALU_POW, 16'd0, 16'd0, "pow_0_0");
        run_op(ALU_POW, 16'd0, 16'd9, "pow_0_9");
        run_op(ALU_POW, 16'd1, 16'hFFFF, "pow_1_ffff");
    endtask

    task automatic test_rad_edges();
        run_op(ALU_RAD, 16'hFFFF, 16'd0, "rad_ffff");
        run_op(ALU_RAD, 16'd17, 16'd0, "rad_17");
        run_op(ALU_RAD, 16'd0, 16'd0, "rad_0");
    endtask

    task automatic test_flags_hold();
        logic [3:0] held;
        held = exp_flags;
        @(negedge clk);
        opsel = ALU_ADD;
        srcA  = 16'h5555;
        #1;
        checks++;
        if (flags !== held || ready !== 1'b1) begin
            failures++;
            $display("FAIL flags_hold: flags=%b ready=%b want %b 1",
                     flags, ready, held);
        end
    endtask

    task automatic test_back_to_back();
        run_op(ALU_POW, 16'd2, 16'd3, "b2b_pow");
        run_op(ALU_RAD, 16'd64, 16'd0, "b2b_rad");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                a = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(12, 0))
                                                : 16'($urandom);
                b = 16'($urandom_range(20, 0));
                run_op(ALU_POW, a, b, "rand_pow");
            end else begin
                run_op(ALU_RAD, 16'($urandom), 16'($urandom), "rand_rad");
            end
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        opsel = ALU_POW;
        srcA  = 16'd3;
        srcB  = 16'd9;
        @(negedge clk);
        opsel = ALU_ADD;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        srcA = 16'h0042;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || flags !== 4'b0
            || result !== 16'h0042) begin
            failures++;
            $display("FAIL reset_mid_op: ready=%b busy=%b flags=%b result=%h",
                     ready, busy, flags, result);
        end
        exp_flags = 4'b0;
        run_op(ALU_RAD, 16'd49, 16'd0, "rad_49_after_rst");
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        exp_flags = 4'b0;
        test_reset();
        test_passthrough();
        test_pow_edges();
        test_flags_hold();
        test_rad_edges();
        test_back_to_back();
        test_random();
        test_passthrough();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
